// File: rtl/layer_compositor.sv
// layer_compositor
//   Per-pixel sequencer sharing one combinational palette between stacked
//   sprite layers. On pix_start the layer indices/enables are snapshotted,
//   then presented to the palette one layer per cycle (layer 0 first). The
//   first opaque layer wins; if none is opaque the background color wins.
//
// Ports
//   Clk, Reset                    clock, asynchronous active-high reset
//   pix_start                     one-cycle strobe starting a pixel
//   layer_idx[4*NUM_LAYERS-1:0]   color index per layer (layer k at [4k+3:4k])
//   layer_en[NUM_LAYERS-1:0]      per-layer enable (disabled = transparent)
//   pal_color                     index driven to the shared palette
//   pal_transparent, pal_red/green/blue  palette result for pal_color
//   busy                          high while scanning layers
//   pix_valid                     one-cycle pulse, result registers updated
//   Red/Green/Blue                composited color, held until next pix_valid
//   win_layer                     winning layer (0 when bg_hit)
//   bg_hit                        background color won
//   overrun                       pulse when pix_start arrives while busy
//
// Optional build macro COLLISION_DETECT_EN
//   Adds clear_collision input and sticky collision output. When layer 0 is
//   opaque the scan runs through all layers and flags any other opaque layer.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter logic [23:0] BG_RGB     = 24'hF7F7F7
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_start,
  input  logic [4*NUM_LAYERS-1:0]       layer_idx,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [3:0]                    pal_color,
  input  logic                          pal_transparent,
  input  logic [7:0]                    pal_red,
  input  logic [7:0]                    pal_green,
  input  logic [7:0]                    pal_blue,
  output logic                          busy,
  output logic                          pix_valid,
  output logic [7:0]                    Red,
  output logic [7:0]                    Green,
  output logic [7:0]                    Blue,
  output logic [$clog2(NUM_LAYERS)-1:0] win_layer,
  output logic                          bg_hit,
  output logic                          overrun
`ifdef COLLISION_DETECT_EN
  ,
  input  logic                          clear_collision,
  output logic                          collision
`endif
);

  localparam int unsigned WL = $clog2(NUM_LAYERS);
  localparam logic [WL-1:0] LAST = WL'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [WL-1:0]                k_q, k_d;
  logic [NUM_LAYERS-1:0][3:0]   snap_idx_q, snap_idx_d;
  logic [NUM_LAYERS-1:0]        snap_en_q, snap_en_d;
  logic [23:0]                  rgb_q, rgb_d;
  logic [WL-1:0]                win_q, win_d;
  logic                         bg_q, bg_d;
  logic                         overrun_q, overrun_d;
  logic                         opaque;
  logic                         is_last;

`ifdef COLLISION_DETECT_EN
  // Layer 0 won but the scan continues; its color waits here so the visible
  // result registers only change together with pix_valid.
  logic                         l0_hit_q, l0_hit_d;
  logic [23:0]                  l0_rgb_q, l0_rgb_d;
  logic                         coll_q, coll_d;
  logic                         coll_set;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_idx_d = snap_idx_q;
    snap_en_d  = snap_en_q;
    rgb_d      = rgb_q;
    win_d      = win_q;
    bg_d       = bg_q;
    overrun_d  = 1'b0;
    pal_color  = 4'h0;
    opaque     = 1'b0;
    is_last    = (k_q == LAST);
`ifdef COLLISION_DETECT_EN
    l0_hit_d   = l0_hit_q;
    l0_rgb_d   = l0_rgb_q;
    coll_set   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (pix_start) begin
          snap_idx_d = layer_idx;
          snap_en_d  = layer_en;
          k_d        = '0;
          state_d    = S_SCAN;
`ifdef COLLISION_DETECT_EN
          l0_hit_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SCAN: begin
        pal_color = snap_idx_q[k_q];
        opaque    = snap_en_q[k_q] & ~pal_transparent;
        overrun_d = pix_start;
`ifdef COLLISION_DETECT_EN
        if (l0_hit_q) begin
          coll_set = opaque;
          if (is_last) begin
            rgb_d   = l0_rgb_q;
            win_d   = '0;
            bg_d    = 1'b0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + WL'(1);
          end
        end else if (opaque) begin
          if (k_q == '0) begin
            l0_hit_d = 1'b1;
            l0_rgb_d = {pal_red, pal_green, pal_blue};
            k_d      = k_q + WL'(1);
          end else begin
            rgb_d   = {pal_red, pal_green, pal_blue};
            win_d   = k_q;
            bg_d    = 1'b0;
            state_d = S_DONE;
          end
        end else if (is_last) begin
          rgb_d   = BG_RGB;
          win_d   = '0;
          bg_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + WL'(1);
        end
`else
        if (opaque) begin
          rgb_d   = {pal_red, pal_green, pal_blue};
          win_d   = k_q;
          bg_d    = 1'b0;
          state_d = S_DONE;
        end else if (is_last) begin
          rgb_d   = BG_RGB;
          win_d   = '0;
          bg_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + WL'(1);
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase

`ifdef COLLISION_DETECT_EN
    // Clear has priority over a set in the same cycle.
    coll_d = clear_collision ? 1'b0 : (coll_q | coll_set);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      snap_idx_q <= '0;
      snap_en_q  <= '0;
      rgb_q      <= '0;
      win_q      <= '0;
      bg_q       <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef COLLISION_DETECT_EN
      l0_hit_q   <= 1'b0;
      l0_rgb_q   <= '0;
      coll_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      snap_idx_q <= snap_idx_d;
      snap_en_q  <= snap_en_d;
      rgb_q      <= rgb_d;
      win_q      <= win_d;
      bg_q       <= bg_d;
      overrun_q  <= overrun_d;
`ifdef COLLISION_DETECT_EN
      l0_hit_q   <= l0_hit_d;
      l0_rgb_q   <= l0_rgb_d;
      coll_q     <= coll_d;
`endif
    end
  end

  assign busy      = (state_q == S_SCAN);
  assign pix_valid = (state_q == S_DONE);
  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign win_layer = win_q;
  assign bg_hit    = bg_q;
  assign overrun   = overrun_q;
`ifdef COLLISION_DETECT_EN
  assign collision = coll_q;
`endif

endmodule
